// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: I/O window decode, HEX/LEDR registers and debounced KEY/SW with ready/overrun status
module mmio_io_ctrl #(
    parameter int                DBITS           = 32,
    parameter int                DEBOUNCE_CYCLES = 100000,
    parameter logic [DBITS-1:0]  ADDR_HEX        = 32'hF0000000,
    parameter logic [DBITS-1:0]  ADDR_LEDR       = 32'hF0000004,
    parameter logic [DBITS-1:0]  ADDR_LEDG       = 32'hF0000008,
    parameter logic [DBITS-1:0]  ADDR_KEY        = 32'hF0000010,
    parameter logic [DBITS-1:0]  ADDR_SW         = 32'hF0000014,
    parameter logic [DBITS-1:0]  ADDR_KCTRL      = 32'hF0000110,
    parameter logic [DBITS-1:0]  ADDR_SCTRL      = 32'hF0000114
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wdata,
    input  logic             we,
    input  logic             re,
    output logic [DBITS-1:0] rdata,
    output logic             io_hit,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [9:0]       LEDR,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [15:0]   hex_q, hex_d;
    logic [9:0]    ledr_q, ledr_d;
    logic [3:0]    ks1_q, ks2_q, kst_q, kst_d;
    logic [9:0]    ss1_q, ss2_q, sst_q, sst_d;
    logic [CW-1:0] kcnt_q, kcnt_d, scnt_q, scnt_d;
    logic          krdy_q, krdy_d, kov_q, kov_d, srdy_q, srdy_d, sov_q, sov_d;
    logic          k_com, s_com, k_rd, s_rd;
    logic          sel_hex, sel_ledr, sel_key, sel_sw, sel_kctrl, sel_sctrl;
    logic          unused_wdata;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign unused_wdata = ^wdata[DBITS-1:16];

    // Full-width compares: misaligned addresses never select a register
    assign io_hit    = addr[DBITS-1:9] == ADDR_HEX[DBITS-1:9];
    assign sel_hex   = addr == ADDR_HEX;
    assign sel_ledr  = addr == ADDR_LEDR;
    assign sel_key   = addr == ADDR_KEY;
    assign sel_sw    = addr == ADDR_SW;
    assign sel_kctrl = addr == ADDR_KCTRL;
    assign sel_sctrl = addr == ADDR_SCTRL;

    assign rdata = sel_hex   ? DBITS'(hex_q)  :
                   sel_ledr  ? DBITS'(ledr_q) :
                   sel_key   ? DBITS'(kst_q)  :
                   sel_sw    ? DBITS'(sst_q)  :
                   sel_kctrl ? DBITS'({kov_q, 1'b0, krdy_q}) :
                   sel_sctrl ? DBITS'({sov_q, 1'b0, srdy_q}) : '0;

    assign LEDR = ledr_q;
    assign HEX0 = seg7(hex_q[3:0]);
    assign HEX1 = seg7(hex_q[7:4]);
    assign HEX2 = seg7(hex_q[11:8]);
    assign HEX3 = seg7(hex_q[15:12]);

    // Counter restarts whenever the synced value is about to move or already matches stable
    always_comb begin
        k_com  = ks1_q == ks2_q && ks2_q != kst_q && kcnt_q == CMAX;
        s_com  = ss1_q == ss2_q && ss2_q != sst_q && scnt_q == CMAX;
        kcnt_d = (ks1_q != ks2_q || ks2_q == kst_q || k_com) ? '0 : kcnt_q + 1'b1;
        scnt_d = (ss1_q != ss2_q || ss2_q == sst_q || s_com) ? '0 : scnt_q + 1'b1;
        kst_d  = k_com ? ks2_q : kst_q;
        sst_d  = s_com ? ss2_q : sst_q;
        k_rd   = re && sel_key;
        s_rd   = re && sel_sw;
        krdy_d = k_com || (krdy_q && !k_rd);
        srdy_d = s_com || (srdy_q && !s_rd);
        kov_d  = (we && sel_kctrl && !wdata[2]) ? 1'b0 : kov_q || (k_com && krdy_q && !k_rd);
        sov_d  = (we && sel_sctrl && !wdata[2]) ? 1'b0 : sov_q || (s_com && srdy_q && !s_rd);
        hex_d  = (we && sel_hex) ? wdata[15:0] : hex_q;
        ledr_d = (we && sel_ledr) ? wdata[9:0] : ledr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_q  <= '0;
            ledr_q <= '0;
            ks1_q  <= '0;
            ks2_q  <= '0;
            kst_q  <= '0;
            ss1_q  <= '0;
            ss2_q  <= '0;
            sst_q  <= '0;
            kcnt_q <= '0;
            scnt_q <= '0;
            krdy_q <= 1'b0;
            kov_q  <= 1'b0;
            srdy_q <= 1'b0;
            sov_q  <= 1'b0;
        end else begin
            hex_q  <= hex_d;
            ledr_q <= ledr_d;
            ks1_q  <= ~KEY;
            ks2_q  <= ks1_q;
            kst_q  <= kst_d;
            ss1_q  <= SW;
            ss2_q  <= ss1_q;
            sst_q  <= sst_d;
            kcnt_q <= kcnt_d;
            scnt_q <= scnt_d;
            krdy_q <= krdy_d;
            kov_q  <= kov_d;
            srdy_q <= srdy_d;
            sov_q  <= sov_d;
        end
    end
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: directed and random checks of mmio_io_ctrl against a behavioural model
module tb_mmio_io_ctrl;
    localparam int D = 4;
    localparam logic [31:0] A_HEX   = 32'hF0000000;
    localparam logic [31:0] A_LEDR  = 32'hF0000004;
    localparam logic [31:0] A_LEDG  = 32'hF0000008;
    localparam logic [31:0] A_KEY   = 32'hF0000010;
    localparam logic [31:0] A_SW    = 32'hF0000014;
    localparam logic [31:0] A_KCTRL = 32'hF0000110;
    localparam logic [31:0] A_SCTRL = 32'hF0000114;

    logic        clk = 1'b0;
    logic        reset_n, we, re, io_hit;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  KEY;
    logic [9:0]  SW, LEDR;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;
    int          errs = 0;
    int          checks = 0;

    logic [6:0]  SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [31:0] AL [10] = '{A_HEX, A_LEDR, A_LEDG, A_KEY, A_SW, A_KCTRL, A_SCTRL,
                             32'hF0000018, 32'hF0000111, 32'h00000040};

    logic [15:0] m_hex;
    logic [9:0]  m_ledr, m_sw;
    logic [3:0]  m_key;
    logic        m_krdy, m_kov, m_srdy, m_sov;
    logic [3:0]  kh [$];
    logic [9:0]  sh [$];

    always #5 clk = ~clk;

    mmio_io_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .io_hit(io_hit), .KEY(KEY), .SW(SW), .LEDR(LEDR),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [31:0] a);
        if (a == A_HEX)   return {16'h0, m_hex};
        if (a == A_LEDR)  return {22'h0, m_ledr};
        if (a == A_KEY)   return {28'h0, m_key};
        if (a == A_SW)    return {22'h0, m_sw};
        if (a == A_KCTRL) return {29'h0, m_kov, 1'b0, m_krdy};
        if (a == A_SCTRL) return {29'h0, m_sov, 1'b0, m_srdy};
        return 32'h0;
    endfunction

    task automatic mreset();
        m_hex = 0; m_ledr = 0; m_key = 0; m_sw = 0;
        m_krdy = 0; m_kov = 0; m_srdy = 0; m_sov = 0;
        kh = {}; sh = {};
        repeat (D + 1) begin kh.push_back(4'h0); sh.push_back(10'h0); end
    endtask

    // A value is committed once it has sat on the pins for D+1 consecutive sampled edges
    task automatic medge();
        logic kc, sc, krd, srd;
        kc = kh[0] != m_key;
        sc = sh[0] != m_sw;
        foreach (kh[i]) if (kh[i] != kh[0]) kc = 0;
        foreach (sh[i]) if (sh[i] != sh[0]) sc = 0;
        krd = re && addr == A_KEY;
        srd = re && addr == A_SW;
        if (we && addr == A_KCTRL && !wdata[2]) m_kov = 0; else if (kc && m_krdy && !krd) m_kov = 1;
        if (we && addr == A_SCTRL && !wdata[2]) m_sov = 0; else if (sc && m_srdy && !srd) m_sov = 1;
        if (kc) m_krdy = 1; else if (krd) m_krdy = 0;
        if (sc) m_srdy = 1; else if (srd) m_srdy = 0;
        if (kc) m_key = kh[0];
        if (sc) m_sw = sh[0];
        if (we && addr == A_HEX) m_hex = wdata[15:0];
        if (we && addr == A_LEDR) m_ledr = wdata[9:0];
        kh.push_front(~KEY); void'(kh.pop_back());
        sh.push_front(SW);   void'(sh.pop_back());
    endtask

    task automatic cyc();
        #1;
        chk("io_hit", {31'h0, io_hit}, {31'h0, addr >= 32'hF0000000 && addr <= 32'hF00001FF});
        chk("rdata", rdata, mrd(addr));
        @(posedge clk);
        medge();
        @(negedge clk);
        chk("LEDR", {22'h0, LEDR}, {22'h0, m_ledr});
        chk("HEX", {4'h0, HEX3, HEX2, HEX1, HEX0},
            {4'h0, SEG[m_hex[15:12]], SEG[m_hex[11:8]], SEG[m_hex[7:4]], SEG[m_hex[3:0]]});
    endtask

    task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        we = w; re = r; addr = a; wdata = d;
        cyc();
    endtask

    task automatic idle(input int n);
        repeat (n) bus(0, 0, A_SCTRL, 0);
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        we = 0; re = 0; addr = a;
        #1 chk(tag, rdata, exp);
    endtask

    initial begin
        reset_n = 0; KEY = 4'hF; SW = 0; we = 0; re = 0; addr = A_KCTRL; wdata = 0;
        mreset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, {4{7'b1000000}}});
        chk("rst_ledr", {22'h0, LEDR}, 32'h0);
        chk("rst_kctrl", rdata, 32'h0);
        @(negedge clk);
        reset_n = 1;

        bus(1, 0, A_HEX, 32'hFFFFA5F0);
        bus(1, 0, A_LEDR, 32'h000002AA);
        chk("wr_hex0", {25'h0, HEX0}, {25'h0, 7'b1000000});
        chk("wr_hex1", {25'h0, HEX1}, {25'h0, 7'b0001110});
        chk("wr_hex2", {25'h0, HEX2}, {25'h0, 7'b0010010});
        chk("wr_hex3", {25'h0, HEX3}, {25'h0, 7'b0001000});
        chk("wr_ledr", {22'h0, LEDR}, 32'h2AA);
        peek("rb_hex", A_HEX, 32'hA5F0);
        peek("rb_ledr", A_LEDR, 32'h2AA);
        bus(1, 0, A_LEDG, 32'hFFFFFFFF);
        bus(1, 0, A_KEY, 32'hF);
        bus(1, 0, 32'hF0000001, 32'h1);
        peek("rb_ledg", A_LEDG, 32'h0);
        peek("rb_key_ro", A_KEY, 32'h0);

        SW = 10'h001; idle(3);
        SW = 10'h000; idle(6);
        peek("glitch_sctrl", A_SCTRL, 32'h0);
        peek("glitch_sw", A_SW, 32'h0);
        SW = 10'h001; idle(5);
        peek("sw_early", A_SW, 32'h0);
        idle(1);
        peek("sw_commit", A_SW, 32'h1);
        peek("sctrl_rdy", A_SCTRL, 32'h1);

        bus(0, 1, A_SW, 0);
        peek("sctrl_clr", A_SCTRL, 32'h0);

        KEY = 4'b1110; idle(8);
        peek("kctrl_rdy", A_KCTRL, 32'h1);
        KEY = 4'b1100; idle(8);
        peek("kctrl_ovr", A_KCTRL, 32'h5);
        peek("key_val", A_KEY, 32'h3);
        bus(1, 0, A_KCTRL, 32'h4);
        peek("kctrl_w1", A_KCTRL, 32'h5);
        bus(1, 0, A_KCTRL, 32'h0);
        peek("kctrl_w0", A_KCTRL, 32'h1);
        bus(0, 1, A_KEY, 0);
        peek("kctrl_rd", A_KCTRL, 32'h0);

        SW = 10'h002; idle(8);
        peek("sim_pre", A_SCTRL, 32'h1);
        SW = 10'h003; idle(5);
        bus(0, 1, A_SW, 0);
        peek("sim_sctrl", A_SCTRL, 32'h1);
        peek("sim_sw", A_SW, 32'h3);
        peek("out_rdata", 32'h00000040, 32'h0);
        chk("out_hit", {31'h0, io_hit}, 32'h0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) KEY = 4'($urandom);
            if ($urandom_range(0, 11) == 0) SW = 10'($urandom);
            bus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, AL[$urandom_range(0, 9)], $urandom);
        end

        KEY = 4'hF; SW = 0;
        bus(1, 0, A_LEDR, 32'h3FF);
        bus(1, 0, A_HEX, 32'h1234);
        chk("pre_hex0", {25'h0, HEX0}, {25'h0, 7'b0011001});
        #2 reset_n = 0;
        addr = A_KCTRL;
        #1;
        chk("mid_rst_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, {4{7'b1000000}}});
        chk("mid_rst_ledr", {22'h0, LEDR}, 32'h0);
        chk("mid_rst_kctrl", rdata, 32'h0);
        mreset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
